// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state encodings and port indices for the SRAM arbiter
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/sram_req_latch.sv
// sram_req_latch: per-port request capture, busy flag and read-data register
module sram_req_latch
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              done,
    input  logic              rd_load,
    input  logic [DATA_W-1:0] rd_in,
    output logic              busy,
    output logic              pend,
    output logic              cur_we,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_wdata,
    output logic [DATA_W-1:0] rdata
);
    logic              busy_q, busy_d, we_q, we_d, cap;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    assign busy      = busy_q & ~done;
    assign cap       = req & ~busy;
    assign pend      = busy | req;
    assign cur_we    = cap ? we : we_q;
    assign cur_addr  = cap ? addr : addr_q;
    assign cur_wdata = cap ? wdata : wdata_q;
    assign rdata     = rdata_q;

    always_comb begin
        busy_d  = cap | busy;
        we_d    = cur_we;
        addr_d  = cur_addr;
        wdata_d = cur_wdata;
        rdata_d = rd_load ? rd_in : rdata_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port arbiter sequencing setup/access/hold cycles on one external SRAM
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2,
    parameter int PRIO_B        = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_busy,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_busy,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_we_n
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d, last_q, last_d, gwe_q, gwe_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d, we_n_q, we_n_d;
    logic              a_pend, b_pend, a_cur_we, b_cur_we, pick_b, rd_sample;
    logic [ADDR_W-1:0] a_cur_addr, b_cur_addr, sel_addr;
    logic [DATA_W-1:0] a_cur_wdata, b_cur_wdata, sel_wdata;

    assign a_ack      = state_q == HOLD && gnt_q == PORT_A;
    assign b_ack      = state_q == HOLD && gnt_q == PORT_B;
    assign rd_sample  = state_q == ACCESS && cnt_q == '0 && !gwe_q;
    assign pick_b     = b_pend & (~a_pend | (PRIO_B != 0) | (last_q == PORT_A));
    assign sel_addr   = pick_b ? b_cur_addr : a_cur_addr;
    assign sel_wdata  = pick_b ? b_cur_wdata : a_cur_wdata;
    assign sram_a     = sram_a_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;

    sram_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_a (
        .clk_sys(clk_sys), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr),
        .wdata(a_wdata), .done(a_ack), .rd_load(rd_sample && gnt_q == PORT_A),
        .rd_in(sram_dq_i), .busy(a_busy), .pend(a_pend), .cur_we(a_cur_we),
        .cur_addr(a_cur_addr), .cur_wdata(a_cur_wdata), .rdata(a_rdata)
    );

    sram_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_b (
        .clk_sys(clk_sys), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr),
        .wdata(b_wdata), .done(b_ack), .rd_load(rd_sample && gnt_q == PORT_B),
        .rd_in(sram_dq_i), .busy(b_busy), .pend(b_pend), .cur_we(b_cur_we),
        .cur_addr(b_cur_addr), .cur_wdata(b_cur_wdata), .rdata(b_rdata)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        gwe_d    = gwe_q;
        cnt_d    = cnt_q;
        sram_a_d = sram_a_q;
        dq_o_d   = dq_o_q;
        dq_oe_d  = dq_oe_q;
        we_n_d   = 1'b1;
        unique case (state_q)
            IDLE, HOLD: begin
                if (a_pend | b_pend) begin
                    state_d  = SETUP;
                    gnt_d    = pick_b;
                    last_d   = pick_b;
                    gwe_d    = pick_b ? b_cur_we : a_cur_we;
                    sram_a_d = sel_addr;
                    dq_o_d   = gwe_d ? sel_wdata : dq_o_q;
                    dq_oe_d  = gwe_d;
                end else begin
                    state_d = IDLE;
                    dq_oe_d = 1'b0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CW'(ACCESS_CYCLES - 1);
                we_n_d  = ~gwe_q;
            end
            ACCESS: begin
                state_d = cnt_q == '0 ? HOLD : ACCESS;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                we_n_d  = cnt_q == '0 ? 1'b1 : ~gwe_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= PORT_A;
            last_q   <= PORT_A;
            gwe_q    <= 1'b0;
            cnt_q    <= '0;
            sram_a_q <= '0;
            dq_o_q   <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            gwe_q    <= gwe_d;
            cnt_q    <= cnt_d;
            sram_a_q <= sram_a_d;
            dq_o_q   <= dq_o_d;
            dq_oe_q  <= dq_oe_d;
            we_n_q   <= we_n_d;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random checks against a transaction-level arbiter model
module tb_sram_port_arbiter;
    localparam int AC = 2;
    localparam int PB = 1;

    logic        clk_sys = 0, reset = 1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [18:0] a_addr = 0, b_addr = 0;
    logic [7:0]  a_wdata = 0, b_wdata = 0;
    logic        a_busy, a_ack, b_busy, b_ack, sram_dq_oe, sram_we_n;
    logic [7:0]  a_rdata, b_rdata, sram_dq_o, sram_dq_i;
    logic [18:0] sram_a;

    int n_cmp = 0, n_err = 0;

    sram_port_arbiter #(.ADDR_W(19), .DATA_W(8), .ACCESS_CYCLES(AC), .PRIO_B(PB)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_busy(a_busy), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_busy(b_busy), .b_ack(b_ack), .b_rdata(b_rdata),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] sram_mem [0:1023];
    logic [7:0] ref_mem  [0:1023];
    assign sram_dq_i = sram_mem[sram_a[9:0]];
    always @(posedge clk_sys) if (!sram_we_n) sram_mem[sram_a[9:0]] <= sram_dq_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: each granted access occupies AC+2 cycles, phase 0 = setup.
    logic        m_pend [2], m_we [2], rq [2], rw [2];
    logic [18:0] m_addr [2], ra [2];
    logic [7:0]  m_wd [2], rd [2];
    logic        m_act = 0, m_aw = 0, m_last = 0, m_valid = 0;
    int          m_ap = 0, m_ph = 0;
    logic [18:0] m_aa = 0, e_a = 0;
    logic [7:0]  m_ad = 0, e_dq = 0;
    logic        e_oe = 0, e_wen = 1;
    logic        e_ack [2], e_busy [2];
    logic [7:0]  e_rd [2];

    always @(posedge clk_sys) begin
        rq = '{a_req, b_req}; rw = '{a_we, b_we};
        ra = '{a_addr, b_addr}; rd = '{a_wdata, b_wdata};
        m_valid = 1;
        if (reset) begin
            m_pend = '{0, 0}; m_act = 0; m_last = 0;
            e_a = 0; e_dq = 0; e_oe = 0; e_wen = 1;
            e_ack = '{0, 0}; e_busy = '{0, 0}; e_rd = '{0, 0};
        end else begin
            for (int p = 0; p < 2; p++) begin
                logic acking, vis_busy;
                acking = m_act && m_ph == AC + 1 && m_ap == p;
                vis_busy = m_pend[p] && !acking;
                if (acking) m_pend[p] = 0;
                if (rq[p] && !vis_busy) begin
                    m_pend[p] = 1; m_we[p] = rw[p]; m_addr[p] = ra[p]; m_wd[p] = rd[p];
                end
            end
            if (m_act && m_ph <= AC) m_ph++;
            else begin
                m_act = 0;
                if (m_pend[0] || m_pend[1]) begin
                    m_ap = (m_pend[1] && (!m_pend[0] || PB != 0 || m_last == 0)) ? 1 : 0;
                    m_last = m_ap[0]; m_act = 1; m_ph = 0;
                    m_aw = m_we[m_ap]; m_aa = m_addr[m_ap]; m_ad = m_wd[m_ap];
                end
            end
            e_ack = '{0, 0};
            if (m_act) begin
                if (m_ph == 0) begin
                    e_a = m_aa;
                    if (m_aw) e_dq = m_ad;
                end
                e_oe = m_aw;
                e_wen = !(m_aw && m_ph >= 1 && m_ph <= AC);
                if (m_ph == AC + 1) begin
                    e_ack[m_ap] = 1;
                    if (m_aw) ref_mem[m_aa[9:0]] = m_ad;
                    else e_rd[m_ap] = ref_mem[m_aa[9:0]];
                end
            end else begin
                e_oe = 0; e_wen = 1;
            end
            for (int p = 0; p < 2; p++) e_busy[p] = m_pend[p] && !e_ack[p];
        end
    end

    logic [18:0] prev_a = 0;
    always @(negedge clk_sys) begin
        if (m_valid) begin
            chk("sram_a", 32'(sram_a), 32'(e_a));
            chk("sram_dq_o", 32'(sram_dq_o), 32'(e_dq));
            chk("sram_dq_oe", 32'(sram_dq_oe), 32'(e_oe));
            chk("sram_we_n", 32'(sram_we_n), 32'(e_wen));
            chk("a_ack", 32'(a_ack), 32'(e_ack[0]));
            chk("b_ack", 32'(b_ack), 32'(e_ack[1]));
            chk("a_busy", 32'(a_busy), 32'(e_busy[0]));
            chk("b_busy", 32'(b_busy), 32'(e_busy[1]));
            chk("a_rdata", 32'(a_rdata), 32'(e_rd[0]));
            chk("b_rdata", 32'(b_rdata), 32'(e_rd[1]));
            chk("we_addr_stable", 32'(sram_we_n || sram_a == prev_a), 32'd1);
        end
        prev_a <= sram_a;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    logic [6:1] wen1 = 6'b111001;
    int ta, tb, cnt, hits;

    initial begin
        for (int i = 0; i < 1024; i++) begin sram_mem[i] = 0; ref_mem[i] = 0; end
        idle(3);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_busy", 32'({a_busy, b_busy, a_ack, b_ack, sram_dq_oe}), 32'd0);
        chk("reset_a", 32'(sram_a), 32'd0);
        reset = 0;
        idle(2);
        // single write on B
        b_req = 1; b_we = 1; b_addr = 19'h00123; b_wdata = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_sys); b_req = 0;
            chk("t1_we_n", 32'(sram_we_n), 32'(wen1[k]));
            if (k <= 4) chk("t1_addr", 32'(sram_a), 32'h123);
            chk("t1_b_ack", 32'(b_ack), 32'(k == 4));
        end
        idle(2);
        // read back on A
        a_req = 1; a_we = 0; a_addr = 19'h00123;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_sys); a_req = 0;
            chk("t2_dq_oe", 32'(sram_dq_oe), 32'd0);
            chk("t2_a_ack", 32'(a_ack), 32'(k == 4));
            if (k == 4) chk("t2_rdata", 32'(a_rdata), 32'hA5);
        end
        idle(2);
        // same-cycle tie
        a_req = 1; a_we = 0; a_addr = 19'h00123;
        b_req = 1; b_we = 1; b_addr = 19'h00055; b_wdata = 8'h3C;
        ta = 0; tb = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_sys); a_req = 0; b_req = 0;
            if (a_ack && ta == 0) ta = k;
            if (b_ack && tb == 0) tb = k;
        end
        chk("t3_b_ack_cycle", 32'(tb), 32'd4);
        chk("t3_a_ack_cycle", 32'(ta), 32'd8);
        chk("t3_a_rdata", 32'(a_rdata), 32'hA5);
        idle(2);
        // request while busy is dropped
        a_req = 1; a_we = 0; a_addr = 19'h00200;
        cnt = 0; hits = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_sys);
            a_req = k == 2; a_addr = k == 2 ? 19'h00300 : a_addr;
            if (a_ack) cnt++;
            if (sram_a == 19'h00300) hits++;
        end
        chk("t4_ack_count", 32'(cnt), 32'd1);
        chk("t4_dropped_addr", 32'(hits), 32'd0);
        idle(2);
        // reset in the middle of a write
        b_req = 1; b_we = 1; b_addr = 19'h003F0; b_wdata = 8'h77;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_sys); b_req = 0; reset = k == 2;
            if (k == 3) chk("t5_abort", 32'({sram_we_n, sram_dq_oe, b_busy}), 32'b100);
            if (b_ack) cnt++;
        end
        chk("t5_no_ack", 32'(cnt), 32'd0);
        b_req = 1; b_we = 1; b_addr = 19'h003F1; b_wdata = 8'h5A;
        tb = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_sys); b_req = 0;
            if (b_ack && tb == 0) tb = k;
        end
        chk("t5_recover_ack", 32'(tb), 32'd4);
        // random stress on both ports
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_sys);
            a_req = $urandom_range(0, 2) == 0; a_we = 1'($urandom);
            a_addr = 19'($urandom_range(0, 31)); a_wdata = 8'($urandom);
            b_req = $urandom_range(0, 2) == 0; b_we = 1'($urandom);
            b_addr = 19'($urandom_range(0, 31)); b_wdata = 8'($urandom);
        end
        @(negedge clk_sys); a_req = 0; b_req = 0;
        idle(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
